dm_access_ctrl: RTL and testbench

Sequences and shares the byte-addressed, big-endian data memory (DM, DATA_MEM_SIZE bytes, combinational read, write on posedge) between two requesters.
- Requester m0 is the CPU load/store port; requester m1 is the loader/debug port.
- Round-robin arbitration, one word access per transaction.
- Bounds and alignment checking; registered read data and error response.
- Sits between the requesters and the DM instance, and owns the DM's MemAddr, MemWriteData, MemWrite and MemRead inputs.

---
 rtl/dm_ctrl_pkg.sv | 27 ++
 rtl/rr_arb2.sv | 26 ++
 rtl/dm_access_ctrl.sv | 122 ++++++++++++
 tb/tb_dm_access_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
// The state encoding and requester ids are fixed so waveforms read the same everywhere.
package dm_ctrl_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_RESP   = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      ACCESS = ST_ACCESS,
      RESP   = ST_RESP
   } state_t;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   localparam int DEF_DATA_MEM_SIZE = 128;

   // Word access is out of range when its last byte would fall past the array.
   // The compare is unsigned 32-bit, so addresses near 2^32 never wrap into range.
   function automatic logic addrErr(input logic [31:0] addr, input logic [31:0] memSize,
                                    input logic alignCheck);
      return (addr > (memSize - 32'd4)) || (alignCheck && (addr[1:0] != 2'b00));
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester that did not win last time gets it.
module rr_arb2
   import dm_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       update,
   output logic       win,
   output logic       any
);

   logic lastGnt;

   assign any = |req;
   assign win = (&req) ? ~lastGnt : req[1];

   // Reset to M1 so M0 takes the first tie.
   always_ff @(posedge clk) begin
      if (rst)
         lastGnt <= M1;
      else if (update && any)
         lastGnt <= win;
   end

endmodule

// File: rtl/dm_access_ctrl.sv
// Shares the big-endian data memory between the CPU port (m0) and the loader/debug port (m1),
// one word per transaction, with bounds/alignment checking and a registered response.
//
//   state  | meaning
//   IDLE   | no transaction in flight, waiting for a request
//   ACCESS | latched transaction drives the DM; gnt to its requester
//   RESP   | rvalid/err/rdata to the requester; may accept the next request
module dm_access_ctrl
   import dm_ctrl_pkg::*;
#(
   parameter int DATA_MEM_SIZE = DEF_DATA_MEM_SIZE,
   parameter bit ALIGN_CHECK   = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic        m0_gnt,
   output logic        m0_rvalid,
   output logic [31:0] m0_rdata,
   output logic        m0_err,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m1_gnt,
   output logic        m1_rvalid,
   output logic [31:0] m1_rdata,
   output logic        m1_err,
   output logic [31:0] MemAddr,
   output logic [31:0] MemWriteData,
   output logic        MemWrite,
   output logic        MemRead,
   input  logic [31:0] MemReadData
);

   state_t      state;
   logic        idQ;
   logic        weQ;
   logic [31:0] addrQ;
   logic [31:0] wdataQ;
   logic [31:0] rdata0Q;
   logic [31:0] rdata1Q;

   logic        arbWin;
   logic        arbAny;
   logic        arbUpdate;
   logic        errCond;
   logic        inAccess;
   logic        inResp;
   logic        okAccess;
   logic [31:0] capture;

   assign arbUpdate = (state == IDLE) || (state == RESP);

   rr_arb2 uArb (
      .clk    (clk),
      .rst    (rst),
      .req    ({m1_req, m0_req}),
      .update (arbUpdate),
      .win    (arbWin),
      .any    (arbAny)
   );

   assign errCond  = addrErr(addrQ, 32'(DATA_MEM_SIZE), ALIGN_CHECK);
   assign inAccess = (state == ACCESS);
   assign inResp   = (state == RESP);
   assign okAccess = inAccess && !errCond;
   assign capture  = (weQ || errCond) ? 32'h0 : MemReadData;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         idQ     <= M0;
         weQ     <= 1'b0;
         addrQ   <= 32'h0;
         wdataQ  <= 32'h0;
         rdata0Q <= 32'h0;
         rdata1Q <= 32'h0;
      end else begin
         case (state)
            IDLE, RESP: begin
               if (arbAny) begin
                  state  <= ACCESS;
                  idQ    <= arbWin;
                  weQ    <= (arbWin == M1) ? m1_we    : m0_we;
                  addrQ  <= (arbWin == M1) ? m1_addr  : m0_addr;
                  wdataQ <= (arbWin == M1) ? m1_wdata : m0_wdata;
               end else begin
                  state <= IDLE;
               end
            end
            ACCESS: begin
               state <= RESP;
               if (idQ == M1)
                  rdata1Q <= capture;
               else
                  rdata0Q <= capture;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign m0_gnt    = inAccess && (idQ == M0);
   assign m1_gnt    = inAccess && (idQ == M1);
   assign m0_rvalid = inResp && (idQ == M0);
   assign m1_rvalid = inResp && (idQ == M1);
   assign m0_err    = m0_rvalid && errCond;
   assign m1_err    = m1_rvalid && errCond;
   assign m0_rdata  = rdata0Q;
   assign m1_rdata  = rdata1Q;

   // rst gates the write strobe directly so a reset landing in ACCESS never commits.
   assign MemAddr      = okAccess ? addrQ : 32'h0;
   assign MemWriteData = (okAccess && weQ) ? wdataQ : 32'h0;
   assign MemRead      = okAccess && !weQ;
   assign MemWrite     = okAccess && weQ && !rst;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl: two instances (alignment check on / off), each with its own
// byte-array DM model.
module tb_dm_access_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
   logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
   logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic [31:0] MemAddr, MemWriteData, MemReadData;
   logic        MemWrite, MemRead;

   logic        n0_req = 0, n0_we = 0, n1_req = 0, n1_we = 0;
   logic [31:0] n0_addr = 0, n0_wdata = 0, n1_addr = 0, n1_wdata = 0;
   logic        n0_gnt, n0_rvalid, n0_err, n1_gnt, n1_rvalid, n1_err;
   logic [31:0] n0_rdata, n1_rdata;
   logic [31:0] nMemAddr, nMemWriteData, nMemReadData;
   logic        nMemWrite, nMemRead;

   int checks = 0;
   int errors = 0;

   dm_access_ctrl #(.DATA_MEM_SIZE(128), .ALIGN_CHECK(1'b1)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .MemAddr(MemAddr), .MemWriteData(MemWriteData), .MemWrite(MemWrite),
      .MemRead(MemRead), .MemReadData(MemReadData)
   );

   dm_access_ctrl #(.DATA_MEM_SIZE(128), .ALIGN_CHECK(1'b0)) dutNa (
      .clk(clk), .rst(rst),
      .m0_req(n0_req), .m0_we(n0_we), .m0_addr(n0_addr), .m0_wdata(n0_wdata),
      .m0_gnt(n0_gnt), .m0_rvalid(n0_rvalid), .m0_rdata(n0_rdata), .m0_err(n0_err),
      .m1_req(n1_req), .m1_we(n1_we), .m1_addr(n1_addr), .m1_wdata(n1_wdata),
      .m1_gnt(n1_gnt), .m1_rvalid(n1_rvalid), .m1_rdata(n1_rdata), .m1_err(n1_err),
      .MemAddr(nMemAddr), .MemWriteData(nMemWriteData), .MemWrite(nMemWrite),
      .MemRead(nMemRead), .MemReadData(nMemReadData)
   );

   // Byte-array DM models, big-endian words
   logic [7:0]  mem   [0:127];
   logic [7:0]  memNa [0:127];
   logic        pokeEn = 1'b0;
   logic [6:0]  pokeAddr = 7'd0;
   logic [31:0] pokeData = 32'h0;
   wire  [6:0]  wa  = MemAddr[6:0];
   wire  [6:0]  nwa = nMemAddr[6:0];

   assign MemReadData  = (MemAddr <= 32'd124) ?
                         {mem[wa], mem[wa + 7'd1], mem[wa + 7'd2], mem[wa + 7'd3]} : 32'h0;
   assign nMemReadData = (nMemAddr <= 32'd124) ?
                         {memNa[nwa], memNa[nwa + 7'd1], memNa[nwa + 7'd2], memNa[nwa + 7'd3]} : 32'h0;

   always @(posedge clk) begin
      if (pokeEn) begin
         mem[pokeAddr]         <= pokeData[31:24];
         mem[pokeAddr + 7'd1]  <= pokeData[23:16];
         mem[pokeAddr + 7'd2]  <= pokeData[15:8];
         mem[pokeAddr + 7'd3]  <= pokeData[7:0];
      end else if (MemWrite && MemAddr <= 32'd124) begin
         mem[wa]         <= MemWriteData[31:24];
         mem[wa + 7'd1]  <= MemWriteData[23:16];
         mem[wa + 7'd2]  <= MemWriteData[15:8];
         mem[wa + 7'd3]  <= MemWriteData[7:0];
      end
      if (nMemWrite && nMemAddr <= 32'd124) begin
         memNa[nwa]        <= nMemWriteData[31:24];
         memNa[nwa + 7'd1] <= nMemWriteData[23:16];
         memNa[nwa + 7'd2] <= nMemWriteData[15:8];
         memNa[nwa + 7'd3] <= nMemWriteData[7:0];
      end
   end

   function automatic logic [31:0] memWord(input int a);
      return {mem[a], mem[a + 1], mem[a + 2], mem[a + 3]};
   endfunction

   function automatic logic [31:0] memNaWord(input int a);
      return {memNa[a], memNa[a + 1], memNa[a + 2], memNa[a + 3]};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input logic [6:0] a, input logic [31:0] d);
      pokeEn = 1'b1; pokeAddr = a; pokeData = d;
      tick;
      pokeEn = 1'b0;
   endtask

   task automatic setReq(input bit na, input bit id, input bit req, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata);
      if (na && id)  begin n1_req = req; n1_we = we; n1_addr = addr; n1_wdata = wdata; end
      if (na && !id) begin n0_req = req; n0_we = we; n0_addr = addr; n0_wdata = wdata; end
      if (!na && id) begin m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; end
      if (!na && !id) begin m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; end
   endtask

   // One isolated transaction: capture ACCESS-cycle and RESP-cycle observations, end in IDLE.
   task automatic run1(input bit na, input bit id, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic gntA, output logic wrA,
                       output logic rdA, output logic vldR, output logic errR,
                       output logic [31:0] rdataR);
      setReq(na, id, 1'b1, we, addr, wdata);
      tick;
      gntA = na ? (id ? n1_gnt : n0_gnt) : (id ? m1_gnt : m0_gnt);
      wrA  = na ? nMemWrite : MemWrite;
      rdA  = na ? nMemRead : MemRead;
      setReq(na, id, 1'b0, 1'b0, 32'h0, 32'h0);
      tick;
      vldR   = na ? (id ? n1_rvalid : n0_rvalid) : (id ? m1_rvalid : m0_rvalid);
      errR   = na ? (id ? n1_err : n0_err) : (id ? m1_err : m0_err);
      rdataR = na ? (id ? n1_rdata : n0_rdata) : (id ? m1_rdata : m0_rdata);
      tick;
   endtask

   logic        gA, wA, rA, vR, eR;
   logic [31:0] dR;

   task automatic test_reset;
      logic [75:0] outs;
      rst = 1'b1;
      m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hFFFFFFFF;
      tick;
      tick;
      outs = {m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err,
              MemWrite, MemRead, m0_rdata, m1_rdata} ^ {12'h0, MemAddr, MemWriteData};
      checks++;
      if (outs !== 76'h0 || MemAddr !== 32'h0)
         begin errors++; $display("FAIL reset_outputs got %h exp 0", outs); end
      poke(7'h00, 32'h01020304);
      poke(7'h04, 32'hA0B0C0D0);
      poke(7'h7C, 32'hCAFEF00D);
      poke(7'h20, 32'h55667788);
      setReq(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      rst = 1'b0;
      tick;
      checks++;
      if ({m0_gnt, m1_gnt, MemRead, MemWrite} !== 4'b0)
         begin errors++; $display("FAIL idle_after_reset got %b exp 0000", {m0_gnt, m1_gnt, MemRead, MemWrite}); end
   endtask

   task automatic test_write_read;
      run1(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, gA, wA, rA, vR, eR, dR);
      checks++; if ({gA, wA, vR, eR} !== 4'b1110)
         begin errors++; $display("FAIL wr_handshake got %b exp 1110", {gA, wA, vR, eR}); end
      checks++; if (memWord(32'h10) !== 32'hDEADBEEF)
         begin errors++; $display("FAIL wr_dm_bytes got %h exp deadbeef", memWord(32'h10)); end
      run1(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, gA, wA, rA, vR, eR, dR);
      checks++; if ({gA, rA, wA, vR, eR} !== 5'b11010)
         begin errors++; $display("FAIL rd_handshake got %b exp 11010", {gA, rA, wA, vR, eR}); end
      checks++; if (dR !== 32'hDEADBEEF)
         begin errors++; $display("FAIL rd_data got %h exp deadbeef", dR); end
   endtask

   task automatic test_round_robin;
      logic expG0, expG1, expV0, expV1;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      setReq(1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 32'h0);
      setReq(1'b0, 1'b1, 1'b1, 1'b0, 32'h04, 32'h0);
      for (int c = 1; c <= 8; c++) begin
         tick;
         expG0 = (c == 1) || (c == 5);
         expG1 = (c == 3) || (c == 7);
         expV0 = (c == 2) || (c == 6);
         expV1 = (c == 4) || (c == 8);
         checks++;
         if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== {expG0, expG1, expV0, expV1})
            begin errors++; $display("FAIL rr_cycle%0d got %b exp %b", c,
               {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, {expG0, expG1, expV0, expV1}); end
         if (expV0) begin
            checks++; if (m0_rdata !== 32'h01020304)
               begin errors++; $display("FAIL rr_m0_data got %h exp 01020304", m0_rdata); end
         end
         if (expV1) begin
            checks++; if (m1_rdata !== 32'hA0B0C0D0)
               begin errors++; $display("FAIL rr_m1_data got %h exp a0b0c0d0", m1_rdata); end
         end
      end
      setReq(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      setReq(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      tick;
   endtask

   task automatic test_errors;
      run1(1'b0, 1'b1, 1'b1, 32'h7D, 32'h12345678, gA, wA, rA, vR, eR, dR);
      checks++; if ({gA, wA, vR, eR, dR} !== {4'b1011, 32'h0})
         begin errors++; $display("FAIL err_wr_7d got %b %h exp 1011 0", {gA, wA, vR, eR}, dR); end
      run1(1'b0, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h0, gA, wA, rA, vR, eR, dR);
      checks++; if ({gA, rA, wA, vR, eR, dR} !== {5'b10011, 32'h0})
         begin errors++; $display("FAIL err_rd_wrap got %b %h exp 10011 0", {gA, rA, wA, vR, eR}, dR); end
      run1(1'b0, 1'b0, 1'b0, 32'h02, 32'h0, gA, wA, rA, vR, eR, dR);
      checks++; if ({gA, rA, wA, vR, eR, dR} !== {5'b10011, 32'h0})
         begin errors++; $display("FAIL err_rd_unaligned got %b %h exp 10011 0", {gA, rA, wA, vR, eR}, dR); end
      run1(1'b0, 1'b0, 1'b0, 32'h7C, 32'h0, gA, wA, rA, vR, eR, dR);
      checks++; if ({rA, vR, eR, dR} !== {3'b110, 32'hCAFEF00D})
         begin errors++; $display("FAIL rd_top_word got %b %h exp 110 cafef00d", {rA, vR, eR}, dR); end
   endtask

   task automatic test_no_align;
      run1(1'b1, 1'b0, 1'b1, 32'h01, 32'h11223344, gA, wA, rA, vR, eR, dR);
      checks++; if ({gA, wA, vR, eR} !== 4'b1110)
         begin errors++; $display("FAIL na_wr got %b exp 1110", {gA, wA, vR, eR}); end
      checks++; if (memNaWord(1) !== 32'h11223344)
         begin errors++; $display("FAIL na_dm_bytes got %h exp 11223344", memNaWord(1)); end
      run1(1'b1, 1'b0, 1'b0, 32'h01, 32'h0, gA, wA, rA, vR, eR, dR);
      checks++; if ({vR, eR, dR} !== {2'b10, 32'h11223344})
         begin errors++; $display("FAIL na_rd got %b %h exp 10 11223344", {vR, eR}, dR); end
      run1(1'b1, 1'b0, 1'b0, 32'h7D, 32'h0, gA, wA, rA, vR, eR, dR);
      checks++; if ({rA, vR, eR, dR} !== {3'b011, 32'h0})
         begin errors++; $display("FAIL na_rd_bounds got %b %h exp 011 0", {rA, vR, eR}, dR); end
   endtask

   task automatic test_reset_mid;
      run1(1'b0, 1'b0, 1'b0, 32'h20, 32'h0, gA, wA, rA, vR, eR, dR);
      checks++; if (dR !== 32'h55667788)
         begin errors++; $display("FAIL pre_rst_rd got %h exp 55667788", dR); end
      setReq(1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 32'h99AABBCC);
      tick;
      checks++; if ({m0_gnt, MemWrite} !== 2'b11)
         begin errors++; $display("FAIL rst_mid_access got %b exp 11", {m0_gnt, MemWrite}); end
      rst = 1'b1;
      setReq(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      #1;
      checks++; if (MemWrite !== 1'b0)
         begin errors++; $display("FAIL rst_gates_write got %b exp 0", MemWrite); end
      tick;
      rst = 1'b0;
      checks++;
      if ({m0_gnt, m0_rvalid, m0_err, m0_rdata, MemWrite, MemRead, MemAddr, MemWriteData} !== 100'h0)
         begin errors++; $display("FAIL rst_mid_outputs got %b %h %h exp 0",
            {m0_gnt, m0_rvalid, m0_err, MemWrite, MemRead}, m0_rdata, MemAddr); end
      checks++; if (memWord(32'h20) !== 32'h55667788)
         begin errors++; $display("FAIL rst_mid_dm got %h exp 55667788", memWord(32'h20)); end
      for (int c = 0; c < 2; c++) begin
         tick;
         checks++; if ({m0_gnt, m0_rvalid} !== 2'b00)
            begin errors++; $display("FAIL rst_mid_no_rvalid got %b exp 00", {m0_gnt, m0_rvalid}); end
      end
   endtask

   task automatic test_back_to_back;
      setReq(1'b0, 1'b0, 1'b1, 1'b1, 32'h40, 32'h0BADF00D);
      tick;
      checks++; if ({m0_gnt, m0_rvalid} !== 2'b10)
         begin errors++; $display("FAIL b2b_gnt1 got %b exp 10", {m0_gnt, m0_rvalid}); end
      setReq(1'b0, 1'b0, 1'b1, 1'b1, 32'h44, 32'h12345678);
      tick;
      checks++; if ({m0_gnt, m0_rvalid} !== 2'b01)
         begin errors++; $display("FAIL b2b_resp1 got %b exp 01", {m0_gnt, m0_rvalid}); end
      tick;
      checks++; if ({m0_gnt, MemWrite, MemAddr} !== {2'b11, 32'h44})
         begin errors++; $display("FAIL b2b_gnt2 got %b %h exp 11 44", {m0_gnt, MemWrite}, MemAddr); end
      setReq(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick;
      checks++; if (m0_rvalid !== 1'b1)
         begin errors++; $display("FAIL b2b_resp2 got %b exp 1", m0_rvalid); end
      tick;
      checks++; if ({memWord(32'h40), memWord(32'h44)} !== {32'h0BADF00D, 32'h12345678})
         begin errors++; $display("FAIL b2b_dm got %h %h exp 0badf00d 12345678",
            memWord(32'h40), memWord(32'h44)); end
   endtask

   initial begin
      test_reset;
      test_write_read;
      test_round_robin;
      test_errors;
      test_no_align;
      test_reset_mid;
      test_back_to_back;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
